fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register for the 5-stage RISC-V core; consumes StallF/StallD/FlushD from the
//  hazard unit and the redirect (PCSrcE/PCTargetE) from EX. Holds PCF and issues one instruction-memory request
//  at a time over a req/ready + rvalid handshake. Delivers InstrD/PCD/PCPlus4D/ValidD to decode; a slow memory
//  inserts bubbles and never stalls the rest of the pipe.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h0000_0000 PCF value after reset
//  NOP_INSTR 32'h0000_0013 instruction injected into D for bubbles (addi x0,x0,0)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-high
//  StallF     in   1     hazard unit: do not consume a fetched instruction / do not advance PCF
//  StallD     in   1     hazard unit: hold IF/ID register
//  FlushD     in   1     hazard unit: load bubble into IF/ID
//  PCSrcE     in   1     taken branch/jump resolved in EX
//  PCTargetE  in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  ImemReq    out  1     request valid; ImemAddr stable while ImemReq=1 and ImemReady=0
//  ImemAddr   out  XLEN  fetch address (= PCF)
//  ImemReady  in   1     memory accepts request this cycle
//  ImemRValid in   1     response valid (earliest: cycle after acceptance)
//  ImemRData  in   32    response instruction word
//  InstrD     out  32    IF/ID instruction
//  PCD        out  XLEN  IF/ID PC
//  PCPlus4D   out  XLEN  IF/ID PC+4, modulo 2^XLEN
//  ValidD     out  1     IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async): PCF=RESET_PC, state=FETCH, skid empty, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
//  hold = StallF | StallD | FlushD. "Deliver" = write an instruction into IF/ID and set PCF<=PCF+4.
//  States:
//   FETCH: ImemReq=1. ImemReady=1 -> WAIT (request for current PCF outstanding).
//   WAIT : ImemReq=0. ImemRValid=1 & !hold -> deliver ImemRData, ->FETCH. ImemRValid=1 & hold -> capture
//          data into 1-entry skid buffer, ->HOLD.
//   HOLD : ImemReq=0. !hold -> deliver skid contents, clear skid, ->FETCH.
//   DROP : ImemReq=0. wait for outstanding response; ImemRValid=1 -> discard, ->FETCH.
//  Redirect (PCSrcE=1) overrides stall and delivery: PCF<=PCTargetE&~3 at the edge; no delivery that cycle.
//   Next state: FETCH->FETCH if not accepted this cycle, else DROP; WAIT->DROP, unless ImemRValid=1 same
//   cycle -> FETCH (response discarded); HOLD->FETCH (skid discarded); DROP->DROP or FETCH per ImemRValid.
//  IF/ID register priority per edge: FlushD -> bubble (NOP_INSTR, ValidD=0; PCD/PCPlus4D don't-care, hold)
//   > StallD -> hold all > deliver -> InstrD, PCD=PCF, PCPlus4D=PCF+4, ValidD=1 > else bubble.
//  Responses arriving in FETCH or HOLD are protocol errors and are ignored.
//  Latency: request accept at cycle t, rvalid at t+1 -> valid in D at t+2; next request issued at t+2.
//  PCF+4 and PCPlus4D wrap modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
//  Reset mid-transaction: state returns to FETCH immediately; any later stray response is ignored.
// TESTING
//  T1 reset, zero-wait memory (ready=1, rvalid next cycle) -> D sees PCD 0,4,8 every 2 cycles, ValidD toggles 1/0.
//  T2 rvalid arrives while StallD=1 for 3 cycles -> skid holds word, IF/ID unchanged, word delivered on release.
//  T3 PCSrcE=1, PCTargetE=0x103 while in WAIT -> old response dropped, next ImemAddr=0x100, ValidD=0 in between.
//  T4 FlushD=1 with StallD=1 -> InstrD=0x00000013, ValidD=0 next cycle (flush wins).
//  T5 RESET_PC=0xFFFF_FFFC -> first PCPlus4D=0, next ImemAddr=0x0.
//  T6 assert rst in WAIT, rvalid one cycle after release -> outputs at reset values, response ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register: one outstanding instruction-memory request,
// a one-entry skid buffer for responses that land during a hazard hold, and redirect handling.
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            ImemReq,
   output logic [XLEN-1:0] ImemAddr,
   input  logic            ImemReady,
   input  logic            ImemRValid,
   input  logic [31:0]     ImemRData,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } fetchState_t;

   fetchState_t     stateQ;
   fetchState_t     stateNext;
   logic [XLEN-1:0] pcF;
   logic [XLEN-1:0] pcNext;
   logic [XLEN-1:0] pcPlus4F;
   logic [XLEN-1:0] redirectPc;
   logic [31:0]     skidData;
   logic [31:0]     deliverInstr;
   logic            deliver;
   logic            captureSkid;
   logic            hold;

   assign hold       = StallF | StallD | FlushD;
   assign pcPlus4F   = pcF + XLEN'(4);
   assign redirectPc = PCTargetE & ~XLEN'(3);
   assign ImemAddr   = pcF;

   // Next-state, delivery and PC selection; a redirect pre-empts any delivery.
   always_comb begin
      stateNext    = stateQ;
      deliver      = 1'b0;
      captureSkid  = 1'b0;
      deliverInstr = skidData;
      unique case (stateQ)
         S_FETCH: begin
            if (ImemReady) stateNext = PCSrcE ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (PCSrcE) begin
               stateNext = ImemRValid ? S_FETCH : S_DROP;
            end else if (ImemRValid) begin
               if (!hold) begin
                  deliver      = 1'b1;
                  deliverInstr = ImemRData;
                  stateNext    = S_FETCH;
               end else begin
                  captureSkid = 1'b1;
                  stateNext   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (PCSrcE) begin
               stateNext = S_FETCH;
            end else if (!hold) begin
               deliver   = 1'b1;
               stateNext = S_FETCH;
            end
         end
         S_DROP: begin
            if (ImemRValid) stateNext = S_FETCH;
         end
         default: stateNext = S_FETCH;
      endcase

      if (PCSrcE)       pcNext = redirectPc;
      else if (deliver) pcNext = pcPlus4F;
      else              pcNext = pcF;
   end

   // Fetch control registers; ImemReq is the registered decode of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ   <= S_FETCH;
         pcF      <= RESET_PC;
         ImemReq  <= 1'b1;
         skidData <= '0;
      end else begin
         stateQ  <= stateNext;
         pcF     <= pcNext;
         ImemReq <= (stateNext == S_FETCH);
         if (captureSkid) skidData <= ImemRData;
      end
   end

   // IF/ID register: flush beats stall beats delivery; otherwise a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (deliver) begin
            InstrD   <= deliverInstr;
            PCD      <= pcF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized hazards/memory timing,
// checked every cycle against a transaction-level reference model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, pcSrcE = 1'b0;
   logic [31:0] pcTargetE = '0;
   logic        imemReady = 1'b0, imemRValid = 1'b0;
   logic [31:0] imemRData = '0;
   logic        imemReq, validD, imemReq2, validD2;
   logic [31:0] imemAddr, instrD, pcD, pcPlus4D;
   logic [31:0] imemAddr2, instrD2, pcD2, pcPlus4D2;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst(rst), .StallF(stallF), .StallD(stallD), .FlushD(flushD),
      .PCSrcE(pcSrcE), .PCTargetE(pcTargetE), .ImemReq(imemReq), .ImemAddr(imemAddr),
      .ImemReady(imemReady), .ImemRValid(imemRValid), .ImemRData(imemRData),
      .InstrD(instrD), .PCD(pcD), .PCPlus4D(pcPlus4D), .ValidD(validD)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .rst(rst), .StallF(stallF), .StallD(stallD), .FlushD(flushD),
      .PCSrcE(pcSrcE), .PCTargetE(pcTargetE), .ImemReq(imemReq2), .ImemAddr(imemAddr2),
      .ImemReady(imemReady), .ImemRValid(imemRValid), .ImemRData(imemRData),
      .InstrD(instrD2), .PCD(pcD2), .PCPlus4D(pcPlus4D2), .ValidD(validD2)
   );

   int unsigned nChecks = 0;
   int unsigned nFails  = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // Memory environment: one accepted request, answered after a random delay.
   bit          memBusy = 1'b0;
   logic [31:0] memAddr = '0;
   int          memCnt = 0;
   int          memDelayMax = 0;

   // Reference model: request in flight, stale flag, buffered words, IF/ID contents.
   logic [31:0] mPc, mInstr, mPcD, mPc4D;
   bit          mReqOut, mStale, mValid;
   logic [31:0] mBuf[$];

   task automatic modelReset(input logic [31:0] resetPc);
      mPc = resetPc; mReqOut = 0; mStale = 0; mBuf.delete();
      mInstr = NOP; mPcD = '0; mPc4D = '0; mValid = 0;
   endtask

   function automatic bit modelReq();
      return !mReqOut && (mBuf.size() == 0);
   endfunction

   task automatic modelStep(input bit sF, input bit sD, input bit fD, input bit redir,
                            input logic [31:0] tgt, input bit rdy, input bit rv,
                            input logic [31:0] rd);
      bit          hold, accept, resp, deliver;
      logic [31:0] word, curPc;
      hold    = sF | sD | fD;
      accept  = modelReq() && rdy;
      resp    = mReqOut && rv;
      deliver = 0;
      word    = '0;
      curPc   = mPc;
      if (redir) begin
         mPc = tgt & 32'hFFFF_FFFC;
         mBuf.delete();
         if (resp) begin
            mReqOut = 0; mStale = 0;
         end else if (mReqOut) begin
            mStale = 1;
         end else if (accept) begin
            mReqOut = 1; mStale = 1;
         end
      end else if (resp) begin
         mReqOut = 0;
         if (mStale) mStale = 0;
         else if (!hold) begin deliver = 1; word = rd; end
         else mBuf.push_back(rd);
      end else if (mBuf.size() != 0) begin
         if (!hold) begin deliver = 1; word = mBuf.pop_front(); end
      end else if (accept) begin
         mReqOut = 1; mStale = 0;
      end
      if (deliver) mPc = curPc + 32'd4;
      if (fD) begin
         mInstr = NOP; mValid = 0;
      end else if (!sD) begin
         if (deliver) begin
            mInstr = word; mPcD = curPc; mPc4D = curPc + 32'd4; mValid = 1;
         end else begin
            mInstr = NOP; mValid = 0;
         end
      end
   endtask

   task automatic checkModel();
      checkEq("ImemReq", 32'(imemReq), 32'(modelReq()));
      checkEq("ImemAddr", imemAddr, mPc);
      checkEq("ValidD", 32'(validD), 32'(mValid));
      checkEq("InstrD", instrD, mInstr);
      if (mValid) begin
         checkEq("PCD", pcD, mPcD);
         checkEq("PCPlus4D", pcPlus4D, mPc4D);
      end
   endtask

   // One clock cycle: check, drive at the falling edge, advance model and memory.
   task automatic step(input bit sF, input bit sD, input bit fD, input bit redir,
                       input logic [31:0] tgt, input bit rdy, input bit stray);
      bit          respDone, accepted;
      logic [31:0] accAddr;
      @(negedge clk);
      checkModel();
      stallF = sF; stallD = sD; flushD = fD; pcSrcE = redir; pcTargetE = tgt;
      imemReady  = rdy;
      imemRValid = 1'b0;
      imemRData  = $urandom;
      respDone   = memBusy && (memCnt == 0);
      if (respDone) begin
         imemRValid = 1'b1;
         imemRData  = memWord(memAddr);
      end else if (stray) begin
         imemRValid = 1'b1;
      end
      modelStep(sF, sD, fD, redir, tgt, rdy, imemRValid, imemRData);
      accepted = imemReq && rdy;
      accAddr  = imemAddr;
      @(posedge clk);
      if (respDone) memBusy = 1'b0;
      else if (memBusy) memCnt--;
      if (accepted) begin
         memBusy = 1'b1;
         memAddr = accAddr;
         memCnt  = $urandom_range(memDelayMax, 0);
      end
      #1;
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 0, 0, '0, rdy, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      stallF = 0; stallD = 0; flushD = 0; pcSrcE = 0; imemReady = 0; imemRValid = 0;
      #1;
      checkEq("rst ImemReq", 32'(imemReq), 32'd1);
      checkEq("rst ImemAddr", imemAddr, 32'h0);
      checkEq("rst InstrD", instrD, NOP);
      checkEq("rst PCD", pcD, 32'h0);
      checkEq("rst PCPlus4D", pcPlus4D, 32'h0);
      checkEq("rst ValidD", 32'(validD), 32'd0);
      checkEq("rst wrap ImemAddr", imemAddr2, 32'hFFFF_FFFC);
      modelReset(32'h0);
      memBusy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pStall, pFlush, pRedir, pReady;
      modelReset(32'h0);
      repeat (2) @(posedge clk);
      doReset();

      // Zero-wait memory: PCD 0,4,8 every two cycles, ValidD alternating.
      memDelayMax = 0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         checkEq("t1 bubble ValidD", 32'(validD), 32'd0);
         idle(1);
         checkEq("t1 ValidD", 32'(validD), 32'd1);
         checkEq("t1 PCD", pcD, 32'(i * 4));
         checkEq("t1 InstrD", instrD, memWord(32'(i * 4)));
      end

      // Flush wins over stall.
      step(0, 1, 1, 0, '0, 1, 0);
      checkEq("t4 InstrD", instrD, NOP);
      checkEq("t4 ValidD", 32'(validD), 32'd0);

      // Redirect in WAIT with the response arriving: dropped, refetch at 0x100.
      step(0, 0, 0, 1, 32'h103, 1, 0);
      checkEq("t3 ImemAddr", imemAddr, 32'h100);
      checkEq("t3 ImemReq", 32'(imemReq), 32'd1);
      checkEq("t3 ValidD", 32'(validD), 32'd0);
      idle(1);
      idle(0);
      checkEq("t3 ValidD after", 32'(validD), 32'd1);
      checkEq("t3 PCD", pcD, 32'h100);
      checkEq("t3 PCPlus4D", pcPlus4D, 32'h104);

      // Response during a three-cycle StallD lands in the skid buffer.
      doReset();
      idle(1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, '0, 1, 0);
         checkEq("t2 hold ValidD", 32'(validD), 32'd0);
         checkEq("t2 hold ImemReq", 32'(imemReq), 32'd0);
      end
      idle(1);
      checkEq("t2 ValidD", 32'(validD), 32'd1);
      checkEq("t2 InstrD", instrD, memWord(32'h0));
      checkEq("t2 PCD", pcD, 32'h0);

      // Reset while waiting, then a stray response after release.
      idle(1);
      doReset();
      step(0, 0, 0, 0, '0, 0, 1);
      checkEq("t6 ValidD", 32'(validD), 32'd0);
      checkEq("t6 InstrD", instrD, NOP);
      checkEq("t6 ImemReq", 32'(imemReq), 32'd1);
      checkEq("t6 ImemAddr", imemAddr, 32'h0);

      // PC wrap from the top of the address space.
      doReset();
      idle(1);
      idle(0);
      checkEq("t5 ValidD", 32'(validD2), 32'd1);
      checkEq("t5 PCD", pcD2, 32'hFFFF_FFFC);
      checkEq("t5 PCPlus4D", pcPlus4D2, 32'h0);
      checkEq("t5 ImemAddr", imemAddr2, 32'h0);
      checkEq("t5 ImemReq", 32'(imemReq2), 32'd1);

      // Randomized hazards, redirects and memory latency.
      for (int cfg = 0; cfg < 4; cfg++) begin
         case (cfg)
            0:       begin pStall = 20; pFlush = 5;  pRedir = 5;  pReady = 70;  memDelayMax = 3; end
            1:       begin pStall = 40; pFlush = 10; pRedir = 10; pReady = 50;  memDelayMax = 5; end
            2:       begin pStall = 0;  pFlush = 0;  pRedir = 3;  pReady = 100; memDelayMax = 0; end
            default: begin pStall = 30; pFlush = 3;  pRedir = 15; pReady = 80;  memDelayMax = 1; end
         endcase
         doReset();
         for (int n = 0; n < 700; n++) begin
            step($urandom_range(99, 0) < pStall,
                 $urandom_range(99, 0) < pStall,
                 $urandom_range(99, 0) < pFlush,
                 $urandom_range(99, 0) < pRedir,
                 $urandom,
                 $urandom_range(99, 0) < pReady,
                 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
